// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU program sequencer and the register-file
// datapath that consumes its output.
//   - Instruction word layout: [7:6] op, [5:4] Rk, [3:2] Rj, [1:0] Ri
//   - Sequencer FSM state encodings
//   - instr_field(): extracts a 2-bit field from an instruction word
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int INSTR_W = 8;
    localparam int FIELD_W = 2;

    // Least-significant bit of each instruction field. The datapath decode
    // uses the same constants, so the layout lives in exactly one place.
    localparam int OP_LSB = 6;
    localparam int RK_LSB = 4;
    localparam int RJ_LSB = 2;
    localparam int RI_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic logic [FIELD_W-1:0] instr_field(
        input logic [INSTR_W-1:0] word,
        input int                 lsb
    );
        return word[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/prog_mem.sv
// -----------------------------------------------------------------------------
// prog_mem
// Program memory for the ALU sequencer: DEPTH x W register array with one
// synchronous write port and one asynchronous (combinational) read port.
// Contents are never cleared, so a loaded program survives a reset.
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A write and a read of the same address in one cycle return the old
    // word; the new word is visible from the next cycle on.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Program sequencer for the 4-bit ALU register-file datapath. While idle the
// program is written through the load port; on start the instructions at
// addresses 0..last_addr are issued one per cycle as registered sel_* fields
// qualified by wr_en, followed by a one-cycle done pulse.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   load_en    in   write load_data to load_addr (IDLE only)
//   load_addr  in   program write address
//   load_data  in   instruction word {op, Rk, Rj, Ri}
//   last_addr  in   address of final instruction, captured with start
//   start      in   begin execution at address 0 (IDLE only)
//   abort      in   stop execution without done (RUN only)
//   sel_Ri/Rj/Rk/op  out  instruction fields, held while wr_en is low
//   wr_en      out  sel_* carry a freshly issued instruction
//   busy       out  execution in progress
//   done       out  one-cycle pulse after the last instruction
//   pc         out  address of the next instruction to issue
// -----------------------------------------------------------------------------
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    input  logic [AW-1:0] last_addr,
    input  logic          start,
    input  logic          abort,
    output logic [1:0]    sel_Ri,
    output logic [1:0]    sel_Rj,
    output logic [1:0]    sel_Rk,
    output logic [1:0]    sel_op,
    output logic          wr_en,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc
);

    seq_state_t           state_q, state_d;
    logic [AW-1:0]        pc_q, pc_d;
    logic [AW-1:0]        end_q, end_d;
    logic [1:0]           ri_q, ri_d;
    logic [1:0]           rj_q, rj_d;
    logic [1:0]           rk_q, rk_d;
    logic [1:0]           op_q, op_d;
    logic                 wr_en_q, wr_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 mem_we;
    logic [INSTR_W-1:0]   instr;

    // Loads are only accepted while idle so a running program never changes
    // underneath the read pointer.
    assign mem_we = load_en && (state_q == ST_IDLE);

    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (INSTR_W)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_q),
        .rdata_o (instr)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        end_d   = end_q;
        ri_d    = ri_q;
        rj_d    = rj_q;
        rk_d    = rk_q;
        op_d    = op_q;
        wr_en_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    end_d   = last_addr;
                    busy_d  = 1'b1;
                end
            end

            ST_RUN: begin
                // Abort takes priority over the final-instruction check, and
                // the instruction at pc is dropped rather than issued.
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    ri_d    = instr_field(instr, RI_LSB);
                    rj_d    = instr_field(instr, RJ_LSB);
                    rk_d    = instr_field(instr, RK_LSB);
                    op_d    = instr_field(instr, OP_LSB);
                    wr_en_d = 1'b1;
                    pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
                    if (pc_q == end_q) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // busy stays high through the last issue cycle and falls
                // together with the rising done pulse.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            end_q   <= '0;
            ri_q    <= '0;
            rj_q    <= '0;
            rk_q    <= '0;
            op_q    <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            end_q   <= end_d;
            ri_q    <= ri_d;
            rj_q    <= rj_d;
            rk_q    <= rk_d;
            op_q    <= op_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sel_Ri = ri_q;
    assign sel_Rj = rj_q;
    assign sel_Rk = rk_q;
    assign sel_op = op_q;
    assign wr_en  = wr_en_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign pc     = pc_q;

endmodule
